// File: rtl/sp_peer.sv
// rtl/sp_peer.sv - CNT/SP serial-port peer: byte transmitter and receiver toward a CIA
// TX drives CNT low/high half-periods MSB first; RX shifts SP on synchronized CNT rising edges.
module sp_peer #(
  parameter int unsigned HALF_PERIOD = 16,
  parameter int unsigned GAP         = 32,
  parameter int unsigned RX_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       cnt_in,
  input  logic       sp_in,
  output logic       cnt_out,
  output logic       sp_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_t;

  localparam logic [15:0] HP_LAST  = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  localparam logic [15:0] TO_LAST  = 16'(RX_TIMEOUT - 1);

  state_t      state;
  logic [15:0] tmr;
  logic [3:0]  tx_bits;
  logic [6:0]  tx_sh;
  logic        run;

  logic        cnt_s1, cnt_s2, cnt_d;
  logic        sp_s1, sp_s2, sp_q;
  logic        edge_q;
  logic [2:0]  rx_cnt;
  logic [6:0]  rx_sh;
  logic [15:0] to_cnt;

  logic        hs;
  logic        rx_en;

  // run keeps tx_ready low until the first clock edge after reset release
  assign tx_ready = run && (state == S_IDLE) && (rx_cnt == 3'd0);
  assign hs       = tx_valid && tx_ready;
  assign rx_en    = (state == S_IDLE) && !hs;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state   <= S_IDLE;
      tmr     <= '0;
      tx_bits <= '0;
      tx_sh   <= '0;
      cnt_out <= 1'b1;
      sp_out  <= 1'b1;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        S_IDLE: begin
          if (hs) begin
            state   <= S_LOW;
            tx_sh   <= tx_data[6:0];
            tx_bits <= '0;
            tmr     <= '0;
            cnt_out <= 1'b0;
            sp_out  <= tx_data[7];
          end
        end
        S_LOW: begin
          if (tmr == HP_LAST) begin
            state   <= S_HIGH;
            tmr     <= '0;
            cnt_out <= 1'b1;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        S_HIGH: begin
          if (tmr == HP_LAST) begin
            tmr     <= '0;
            tx_bits <= tx_bits + 4'd1;
            tx_sh   <= {tx_sh[5:0], 1'b0};
            if (tx_bits == 4'd7) begin
              state  <= S_GAP;
              sp_out <= 1'b1;
            end else begin
              state   <= S_LOW;
              cnt_out <= 1'b0;
              sp_out  <= tx_sh[6];
            end
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        S_GAP: begin
          if (tmr == GAP_LAST) begin
            state <= S_IDLE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One extra register stage after edge detection places rx_valid 3 clocks after CNT is first sampled high
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_s1   <= 1'b1;
      cnt_s2   <= 1'b1;
      cnt_d    <= 1'b1;
      sp_s1    <= 1'b1;
      sp_s2    <= 1'b1;
      sp_q     <= 1'b1;
      edge_q   <= 1'b0;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      to_cnt   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      cnt_s1   <= cnt_in;
      cnt_s2   <= cnt_s1;
      cnt_d    <= cnt_s2;
      sp_s1    <= sp_in;
      sp_s2    <= sp_s1;
      sp_q     <= sp_s2;
      edge_q   <= cnt_s2 && !cnt_d && (state == S_IDLE);
      rx_valid <= 1'b0;
      if (edge_q && rx_en) begin
        rx_sh  <= {rx_sh[5:0], sp_q};
        rx_cnt <= rx_cnt + 3'd1;
        to_cnt <= '0;
        if (rx_cnt == 3'd7) begin
          rx_data  <= {rx_sh, sp_q};
          rx_valid <= 1'b1;
        end
      end else if (rx_cnt != 3'd0) begin
        if (to_cnt == TO_LAST) begin
          rx_cnt <= '0;
          rx_sh  <= '0;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sp_peer.sv
// tb/tb_sp_peer.sv - Randomized self-checking bench for sp_peer against a behavioural model
module tb_sp_peer;

  localparam int HP = 4;
  localparam int GP = 5;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       cnt_in = 1'b1;
  logic       sp_in = 1'b1;
  logic       tx_ready, rx_valid, cnt_out, sp_out;
  logic [7:0] rx_data;

  int errors = 0;
  int checks = 0;
  int vcnt = 0;

  sp_peer #(.HALF_PERIOD(HP), .GAP(GP), .RX_TIMEOUT(TO)) dut (
    .clk(clk), .res_n(res_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .cnt_in(cnt_in), .sp_in(sp_in), .cnt_out(cnt_out), .sp_out(sp_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: TX as a queue of per-cycle (cnt,sp) pairs; RX as delayed edge samples.
  typedef struct { int due; logic sp; } pend_t;
  pend_t      pend[$];
  pend_t      m_p;
  logic [1:0] m_q[$];
  logic       m_cnt, m_sp, m_ready, m_valid, m_run, m_prev, m_busy;
  logic [7:0] m_rxd, m_sh;
  int         m_n, cyc, last_p;

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      m_q.delete(); pend.delete();
      m_cnt = 1'b1; m_sp = 1'b1; m_ready = 1'b0; m_valid = 1'b0; m_run = 1'b0;
      m_prev = 1'b1; m_rxd = 8'h00; m_sh = 8'h00; m_n = 0; cyc = 0; last_p = 0;
    end else begin
      cyc++;
      if (tx_valid && m_ready) begin
        for (int i = 7; i >= 0; i--) begin
          for (int j = 0; j < HP; j++) m_q.push_back({1'b0, tx_data[i]});
          for (int j = 0; j < HP; j++) m_q.push_back({1'b1, tx_data[i]});
        end
        for (int j = 0; j < GP; j++) m_q.push_back(2'b11);
      end
      m_busy = (m_q.size() != 0);
      if (m_busy) {m_cnt, m_sp} = m_q.pop_front();
      else {m_cnt, m_sp} = 2'b11;
      if (cnt_in && !m_prev) begin
        m_p.due = cyc + 3; m_p.sp = sp_in; pend.push_back(m_p);
      end
      m_prev = cnt_in;
      m_valid = 1'b0;
      if (pend.size() != 0 && pend[0].due == cyc) begin
        m_p = pend.pop_front();
        if (!m_busy) begin
          m_sh = {m_sh[6:0], m_p.sp};
          m_n++;
          last_p = cyc;
          if (m_n == 8) begin m_n = 0; m_rxd = m_sh; m_valid = 1'b1; end
        end
      end else if (m_n != 0 && cyc - last_p == TO) begin
        m_n = 0; m_sh = 8'h00;
      end
      m_run = 1'b1;
      m_ready = m_run && !m_busy && (m_n == 0);
    end
  end

  always @(negedge clk) begin
    chk("cnt_out", cnt_out, m_cnt);
    chk("sp_out", sp_out, m_sp);
    chk("tx_ready", tx_ready, m_ready);
    chk("rx_valid", rx_valid, m_valid);
    chk("rx_data", rx_data, m_rxd);
    if (rx_valid) vcnt++;
  end

  task automatic rx_bits(input logic [7:0] b, input int first, input int nb, input int lo, input int hi);
    for (int i = first; i < first + nb; i++) begin
      cnt_in = 1'b0; sp_in = b[7-i];
      repeat (lo) @(negedge clk);
      cnt_in = 1'b1;
      @(negedge clk);
      sp_in = 1'($urandom);
      repeat (hi - 1) @(negedge clk);
    end
  endtask

  task automatic tx_send(input logic [7:0] b, output int len, output logic [7:0] seen,
                         output int lows, output int rises);
    int   w;
    logic prev;
    w = 0;
    while (!tx_ready && w < 500) begin @(negedge clk); w++; end
    chk("tx_ready_wait", w < 500, 1);
    tx_valid = 1'b1; tx_data = b;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'($urandom);
    len = 0; lows = 0; rises = 0; seen = 8'h00; prev = 1'b1;
    while (!tx_ready && len < 2000) begin
      if (!prev && cnt_out) begin seen = {seen[6:0], sp_out}; rises++; end
      if (!cnt_out) lows++;
      prev = cnt_out;
      len++;
      @(negedge clk);
      tx_data = 8'($urandom);
    end
  endtask

  initial begin
    logic [7:0] b, seen;
    int len, lows, rises, v0, w;

    repeat (3) @(negedge clk);
    chk("rst_cnt_out", cnt_out, 1);
    chk("rst_sp_out", sp_out, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    res_n = 1'b1;
    chk("ready_before_edge", tx_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_release", tx_ready, 1);
    @(negedge clk);

    tx_send(8'hA5, len, seen, lows, rises);
    chk("a5_bits", seen, 8'hA5);
    chk("a5_lows", lows, 32);
    chk("a5_rises", rises, 8);
    chk("a5_len", len, 69);

    v0 = vcnt;
    rx_bits(8'h3C, 0, 7, 3, 3);
    cnt_in = 1'b0; sp_in = 1'b0;
    repeat (3) @(negedge clk);
    cnt_in = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 chk("3c_early", rx_valid, 0);
    @(posedge clk);
    #1 chk("3c_valid", rx_valid, 1);
    chk("3c_data", rx_data, 8'h3C);
    repeat (6) @(negedge clk);
    chk("3c_pulses", vcnt - v0, 1);

    v0 = vcnt;
    rx_bits(8'hE0, 0, 3, 2, 2);
    chk("partial_blocks_tx", tx_ready, 0);
    repeat (TO + 10) @(negedge clk);
    chk("to_no_pulse", vcnt - v0, 0);
    chk("to_ready", tx_ready, 1);
    rx_bits(8'hFF, 0, 8, 2, 2);
    repeat (6) @(negedge clk);
    chk("ff_pulses", vcnt - v0, 1);
    chk("ff_data", rx_data, 8'hFF);

    v0 = vcnt;
    fork
      tx_send(8'h69, len, seen, lows, rises);
      begin
        repeat (5) @(negedge clk);
        rx_bits(8'($urandom), 0, 3, 2, 2);
      end
    join
    chk("own_cnt_bits", seen, 8'h69);
    chk("own_cnt_ignored", vcnt - v0, 0);

    w = 0;
    while (!tx_ready && w < 500) begin @(negedge clk); w++; end
    tx_valid = 1'b1; tx_data = 8'h4A;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (26) @(negedge clk);
    chk("pre_abort_cnt", cnt_out, 0);
    #2 res_n = 1'b0;
    #1;
    chk("abort_cnt_out", cnt_out, 1);
    chk("abort_sp_out", sp_out, 1);
    chk("abort_tx_ready", tx_ready, 0);
    @(negedge clk);
    res_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_next", tx_ready, 1);
    lows = 0;
    repeat (20) begin @(negedge clk); if (!cnt_out) lows++; end
    chk("abort_no_residual", lows, 0);

    v0 = vcnt;
    b = 8'($urandom);
    rx_bits(b, 0, 4, 2, 3);
    tx_valid = 1'b1; tx_data = 8'h96;
    chk("busy_ready", tx_ready, 0);
    rx_bits(b, 4, 4, 2, 3);
    w = 0;
    while (!tx_ready && w < 50) begin @(negedge clk); w++; end
    chk("busy_wait", w < 50, 1);
    chk("busy_rx_first", rx_valid, 1);
    chk("busy_rx_data", rx_data, b);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("busy_tx_started", cnt_out, 0);
    w = 0;
    while (!tx_ready && w < 500) begin @(negedge clk); w++; end
    chk("busy_tx_done", w < 500, 1);

    for (int r = 0; r < 6; r++) begin
      b = 8'($urandom);
      tx_send(b, len, seen, lows, rises);
      chk("rnd_tx_bits", seen, b);
      chk("rnd_tx_len", len, 16 * HP + GP);
      repeat ($urandom_range(1, 6)) @(negedge clk);
      b = 8'($urandom);
      v0 = vcnt;
      rx_bits(b, 0, 8, $urandom_range(1, 5), $urandom_range(1, 5));
      repeat (6) @(negedge clk);
      chk("rnd_rx_data", rx_data, b);
      chk("rnd_rx_pulses", vcnt - v0, 1);
      if ($urandom_range(0, 1) == 1) begin
        v0 = vcnt;
        rx_bits(8'($urandom), 0, $urandom_range(1, 7), 2, 2);
        repeat (TO + 10) @(negedge clk);
        chk("rnd_partial_dropped", vcnt - v0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sp_peer.md
SP_PEER -- requirements
Module: sp_peer

Interface
REQ-001 HALF_PERIOD, 16, clk cycles per CNT half-period on transmit; legal range 4..65535.
REQ-002 GAP, 32, idle clk cycles after each transmitted byte; legal range 1..65535.
REQ-003 RX_TIMEOUT, 4096, clk cycles without a received CNT rising edge before a partial receive byte is discarded; legal range 16..65535.
REQ-004 clk  input  1  single clock; every flop SHALL be clocked on its rising edge.
REQ-005 res_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 tx_valid  input  1  tx_data holds a byte to send.
REQ-007 tx_data  input  8  byte to send, MSB first.
REQ-008 tx_ready  output  1  byte accepted on a cycle where tx_valid and tx_ready are both high.
REQ-009 rx_valid  output  1  one-cycle pulse when a received byte completes.
REQ-010 rx_data  output  8  last completed received byte.
REQ-011 cnt_in  input  1  CNT pad level from the CIA (CIA cnt_out); asynchronous to clk.
REQ-012 sp_in  input  1  SP pad level from the CIA (CIA sp_out); asynchronous to clk.
REQ-013 cnt_out  output  1  CNT drive toward the CIA; 1 = released/high.
REQ-014 sp_out  output  1  SP drive toward the CIA; 1 = released/high.

Function
REQ-015 cnt_in and sp_in SHALL each pass through a 2-flop synchronizer before any use.
REQ-016 TX state machine SHALL have states IDLE, LOW, HIGH and GAP.
REQ-017 tx_ready SHALL equal (state == IDLE) and not rx_busy, where rx_busy is high while the receive bit count is nonzero.
REQ-018 On handshake in IDLE: latch tx_data into the TX shift register; bit count = 0; enter LOW on the next cycle.
REQ-019 In LOW: cnt_out = 0 and sp_out = current MSB for exactly HALF_PERIOD cycles; then enter HIGH.
REQ-020 In HIGH: cnt_out = 1 and sp_out unchanged for HALF_PERIOD cycles, giving the CIA a stable SP on the rising CNT edge.
REQ-021 At the end of HIGH: shift left and increment the bit count; if 8 bits are sent, enter GAP, otherwise enter LOW.
REQ-022 In GAP: cnt_out = 1 and sp_out = 1 for GAP cycles; then enter IDLE.
REQ-023 In IDLE: cnt_out = 1 and sp_out = 1.
REQ-024 Byte period from the first LOW cycle to the first GAP cycle SHALL be 16*HALF_PERIOD cycles.
REQ-025 tx_data changes while not in IDLE SHALL have no effect.
REQ-026 RX SHALL be disabled while the TX state is not IDLE: no edge detection and no counter advance, so own CNT edges are not received.
REQ-027 RX: on each rising edge of synchronized cnt_in, shift synchronized sp_in into the LSB of the RX shift register and increment the 3-bit count.
REQ-028 On the 8th edge: load rx_data from the full shift value, pulse rx_valid for one cycle, count wraps to 0.
REQ-029 rx_valid SHALL rise exactly 3 clk cycles after the first clk edge at which cnt_in is sampled high.
REQ-030 rx_data SHALL stay stable until the next completed byte; no backpressure exists and unread bytes are overwritten.
REQ-031 The timeout counter SHALL reset on every received edge and count only while the count is nonzero.
REQ-032 On reaching RX_TIMEOUT: clear the count and the shift register, with no rx_valid pulse.
REQ-033 If a handshake and an RX edge occur in the same cycle, TX SHALL win and the RX edge SHALL be ignored; this can occur only when the count is 0.
REQ-034 Counter widths SHALL be 16 bits unsigned; no counter may wrap except the RX bit count.

Reset
REQ-035 While res_n = 0: TX state = IDLE; cnt_out = 1; sp_out = 1; tx_ready = 0; rx_valid = 0; rx_data = 0; all counters, shift registers and synchronizer flops = 1 for CNT/SP and 0 elsewhere.
REQ-036 tx_ready SHALL rise on the first clk edge after res_n deasserts.
REQ-037 Reset mid-byte SHALL abort TX and RX immediately, returning cnt_out and sp_out to 1 without completing the byte.

Verification
REQ-038 HALF_PERIOD=4: send 0xA5 -> cnt_out shows 8 low/high pulses of 4+4 cycles; sp_out shows 1,0,1,0,0,1,0,1 sampled at each cnt_out rising edge; then GAP before tx_ready returns.
REQ-039 Drive 8 CNT rising edges with SP = 0x3C MSB first -> exactly one rx_valid pulse, 3 cycles after the last edge; rx_data = 0x3C.
REQ-040 Loopback through a cia_serial instance in input mode: sp_peer sends 0x81 -> CIA sp_int fires and CIA SDR = 0x81; CIA in output mode sends 0x5A -> sp_peer rx_data = 0x5A.
REQ-041 Send 3 CNT edges, idle for RX_TIMEOUT cycles, then send 8 edges carrying 0xFF -> one rx_valid with rx_data = 0xFF and no earlier pulse.
REQ-042 Assert res_n = 0 during the 4th bit of a TX -> cnt_out = 1 and sp_out = 1 asynchronously; after release, tx_ready = 1 next cycle and no residual pulses.
REQ-043 Hold tx_valid high while an RX byte is half received -> tx_ready = 0 until rx_valid, then TX starts.
